// File: rtl/shift_unit.sv
// Multi-cycle iterative shifter (SLL/SRL/SRA) with valid/ready handshakes feeding the ALU operand-B path.
// Define SHIFT_UNIT_BARREL_EN to replace the iterative datapath with a single-cycle barrel shift at accept.
module shift_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned COARSE  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic [3:0]         control,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt_in,
  output logic               valid_out,
  input  logic               ready_in,
  output logic [WIDTH-1:0]   result
);

  localparam int unsigned AMT_W = SHAMT_W + 1;
  localparam logic [AMT_W-1:0] COARSE_AMT = AMT_W'(COARSE);
  localparam logic [AMT_W-1:0] ONE_AMT    = AMT_W'(1);
  localparam logic [3:0] CTRL_SLL = 4'b0010;
  localparam logic [3:0] CTRL_SRL = 4'b1010;
  localparam logic [3:0] CTRL_SRA = 4'b1011;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;
  typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA} op_e;

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic                 sign_q, sign_d;
  logic                 valid_q, valid_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [SHAMT_W-1:0]   count_q, count_d;

  op_e                  op_in;
  logic                 is_shift;
  logic                 step_coarse;
  logic [WIDTH-1:0]     shift_coarse;
  logic [WIDTH-1:0]     shift_one;
  logic [SHAMT_W-1:0]   count_step;

  // Arithmetic shifts take the fill from the sign latched at accept, not from the working value.
  function automatic logic [WIDTH-1:0] shift_by(input op_e op, input logic sign,
                                                input logic [WIDTH-1:0] val,
                                                input logic [AMT_W-1:0] amt);
    logic signed [WIDTH:0] ext;
    ext = {sign, val};
    case (op)
      OP_SLL:  shift_by = val << amt;
      OP_SRL:  shift_by = val >> amt;
      default: shift_by = WIDTH'(ext >>> amt);
    endcase
  endfunction

  always_comb begin
    op_in    = OP_SLL;
    is_shift = 1'b1;
    case (control)
      CTRL_SLL: op_in = OP_SLL;
      CTRL_SRL: op_in = OP_SRL;
      CTRL_SRA: op_in = OP_SRA;
      default:  is_shift = 1'b0;
    endcase
  end

  // Only two fixed step sizes exist, so the iterative datapath is a pair of constant shifts and a mux.
  assign step_coarse  = {1'b0, count_q} >= COARSE_AMT;
  assign shift_coarse = shift_by(op_q, sign_q, result_q, COARSE_AMT);
  assign shift_one    = shift_by(op_q, sign_q, result_q, ONE_AMT);
  assign count_step   = step_coarse ? (count_q - SHAMT_W'(COARSE)) : (count_q - SHAMT_W'(1));

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_d   = sign_q;
    valid_d  = valid_q;
    result_d = result_q;
    count_d  = count_q;
    if (flush) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          valid_d = 1'b0;
          if (valid_in) begin
            op_d     = op_in;
            sign_d   = data_in[WIDTH-1];
            result_d = data_in;
`ifdef SHIFT_UNIT_BARREL_EN
            if (is_shift) result_d = shift_by(op_in, data_in[WIDTH-1], data_in, {1'b0, shamt_in});
            state_d = ST_DONE;
`else
            if (is_shift && (shamt_in != '0)) begin
              state_d = ST_SHIFT;
              count_d = shamt_in;
            end else begin
              state_d = ST_DONE;
            end
`endif
          end
        end
        ST_SHIFT: begin
          result_d = step_coarse ? shift_coarse : shift_one;
          count_d  = count_step;
          if (count_step == '0) begin
            state_d = ST_DONE;
            valid_d = 1'b1;
          end
        end
        ST_DONE: begin
          // Immediate results spend one cycle here before valid rises, giving a one-edge minimum latency.
          if (valid_q && ready_in) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end else begin
            valid_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_SLL;
      sign_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      count_q  <= count_d;
    end
  end

  assign ready_out = rst_n && (state_q == ST_IDLE);
  assign valid_out = valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench for shift_unit: expected results queued at issue, popped when valid_out is seen.
module tb_shift_unit;

  localparam logic [3:0] C_SLL = 4'b0010;
  localparam logic [3:0] C_SRL = 4'b1010;
  localparam logic [3:0] C_SRA = 4'b1011;
  localparam logic [3:0] C_ADD = 4'b0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        valid_in;
  logic        ready_out;
  logic [3:0]  control;
  logic [31:0] data_in;
  logic [4:0]  shamt_in;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] result;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  shift_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .control   (control),
    .data_in   (data_in),
    .shamt_in  (shamt_in),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [3:0] c, input logic [31:0] d,
                                          input logic [4:0] s);
    case (c)
      C_SLL:   return d << s;
      C_SRL:   return d >> s;
      C_SRA:   return 32'($signed(d) >>> s);
      default: return d;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] c, input logic [4:0] s);
    int steps;
`ifdef SHIFT_UNIT_BARREL_EN
    steps = 1;
`else
    if ((c == C_SLL || c == C_SRL || c == C_SRA) && s != 5'd0)
      steps = int'(s) / 8 + int'(s) % 8;
    else
      steps = 1;
`endif
    return steps;
  endfunction

  // Drive one request; returns at E0 + 1 time unit.
  task automatic issue(input logic [3:0] c, input logic [31:0] d, input logic [4:0] s,
                       input logic [31:0] exp, input bit push);
    int n = 0;
    while (ready_out !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("ready_before_accept", 32'(ready_out), 32'd1);
    control  = c;
    data_in  = d;
    shamt_in = s;
    valid_in = 1'b1;
    if (push) exp_q.push_back(exp);
    @(posedge clk); #1;
    valid_in = 1'b0;
    check("ready_low_after_e0", 32'(ready_out), 32'd0);
  endtask

  task automatic wait_valid(input string tag, input int lat);
    int k = 0;
    while (valid_out !== 1'b1 && k < 100) begin
      @(posedge clk); #1; k++;
    end
    check({tag, "_valid"}, 32'(valid_out), 32'd1);
    check({tag, "_latency"}, 32'(k), 32'(lat));
    check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) check({tag, "_result"}, result, exp_q.pop_front());
  endtask

  task automatic handoff(input string tag);
    check({tag, "_ready_before_handoff"}, 32'(ready_out), 32'd0);
    ready_in = 1'b1;
    @(posedge clk); #1;
    ready_in = 1'b0;
    check({tag, "_valid_after_handoff"}, 32'(valid_out), 32'd0);
    check({tag, "_ready_after_handoff"}, 32'(ready_out), 32'd1);
  endtask

  task automatic run(input string tag, input logic [3:0] c, input logic [31:0] d,
                     input logic [4:0] s, input logic [31:0] exp);
    issue(c, d, s, exp, 1'b1);
    wait_valid(tag, ref_lat(c, s));
    handoff(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0]  rc;
    logic [31:0] rd;
    logic [4:0]  rs;
    rst_n = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
    control = C_ADD; data_in = '0; shamt_in = '0;
    #2;
    check("reset_ready", 32'(ready_out), 32'd0);
    check("reset_valid", 32'(valid_out), 32'd0);
    check("reset_result", result, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", 32'(ready_out), 32'd1);

    run("sra31", C_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    run("sll9",  C_SLL, 32'h0000_0001, 5'd9,  32'h0000_0200);
    run("srl4",  C_SRL, 32'hF000_0000, 5'd4,  32'h0F00_0000);
    run("srl0",  C_SRL, 32'hA5A5_0F0F, 5'd0,  32'hA5A5_0F0F);
    run("add",   C_ADD, 32'h1234_5678, 5'd7,  32'h1234_5678);
    run("sra_pos", C_SRA, 32'h7000_0000, 5'd17, 32'h0000_3800);

    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 2))
        0:       rc = C_SLL;
        1:       rc = C_SRL;
        default: rc = C_SRA;
      endcase
      rd = $urandom;
      rs = 5'($urandom_range(0, 31));
      run("rand", rc, rd, rs, ref_res(rc, rd, rs));
    end

    // Backpressure: result and valid hold while downstream stalls; requests are ignored meanwhile.
    issue(C_SLL, 32'h0000_0003, 5'd2, 32'h0000_000C, 1'b1);
    wait_valid("bp", ref_lat(C_SLL, 5'd2));
    for (int i = 0; i < 5; i++) begin
      valid_in = (i % 2 == 0);
      control  = C_SRL;
      data_in  = 32'hDEAD_BEEF;
      shamt_in = 5'd3;
      @(posedge clk); #1;
      check("bp_result_hold", result, 32'h0000_000C);
      check("bp_valid_hold", 32'(valid_out), 32'd1);
      check("bp_ready_low", 32'(ready_out), 32'd0);
    end
    valid_in = 1'b0;
    handoff("bp");
    @(posedge clk); #1;
    check("bp_no_ghost_accept", 32'(valid_out), 32'd0);

    // Flush in flight, with a simultaneous request that must be dropped.
    issue(C_SRA, 32'hFFFF_0000, 5'd20, 32'h0, 1'b0);
    @(posedge clk); #1;
    flush    = 1'b1;
    valid_in = 1'b1;
    control  = C_SLL;
    data_in  = 32'h0000_0001;
    shamt_in = 5'd1;
    @(posedge clk); #1;
    flush    = 1'b0;
    valid_in = 1'b0;
    check("flush_valid", 32'(valid_out), 32'd0);
    check("flush_ready", 32'(ready_out), 32'd1);
    run("post_flush", C_SRL, 32'h0000_0100, 5'd8, 32'h0000_0001);

    // Asynchronous reset in flight.
    issue(C_SLL, 32'h0000_0001, 5'd9, 32'h0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(valid_out), 32'd0);
    check("arst_ready", 32'(ready_out), 32'd0);
    check("arst_result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("arst_release_ready", 32'(ready_out), 32'd1);
    check("arst_release_result", result, 32'd0);
    run("post_reset", C_SLL, 32'h0000_0001, 5'd1, 32'h0000_0002);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
